rect_fill_ctrl: RTL and testbench
=================================

RECT_FILL_CTRL -- requirements
Module: rect_fill_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of Clock.
REQ-002 Parameter COLS, default 100, SHALL set the framebuffer width in pixels.
REQ-003 Parameter ROWS, default 100, SHALL set the framebuffer height in pixels.
REQ-004 Clock  input  1  system clock.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 iStart  input  1  fill request; sampled only in IDLE.
REQ-007 iX, iY  input  8 each  top-left column and row of the rectangle.
REQ-008 iWidth, iHeight  input  8 each  inclusive extent; columns iX..iX+iWidth and rows iY..iY+iHeight.
REQ-009 iColor  input  3  fill colour, using the same encoding as the VGA instruction colours.
REQ-010 iWriteGrant  input  1  framebuffer arbiter accepts the presented write in this cycle.
REQ-011 oWriteEnable  output  1  pixel write request.
REQ-012 oWriteAddress  output  14  pixel address, computed as row*COLS+col.
REQ-013 oWriteColor  output  3  pixel colour.
REQ-014 oBusy  output  1  high in every state except IDLE.
REQ-015 oDone  output  1  one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have four states (IDLE, SETUP, FILL, DONE), and every output SHALL be driven from registers.
REQ-017 IDLE with iStart=1: latch iX, iY, iColor, and the 9-bit sums iX+iWidth and iY+iHeight; go to SETUP on the next cycle.
REQ-018 SETUP: compute xEnd=min(iX+iWidth, COLS-1) and yEnd=min(iY+iHeight, ROWS-1) using 9-bit arithmetic with no wrap; load col=iX and row=iY.
REQ-019 SETUP with iX>=COLS or iY>=ROWS: go to DONE without issuing any write.
REQ-020 SETUP otherwise: go to FILL.
REQ-021 FILL: hold oWriteEnable=1, with oWriteAddress=row*COLS+col and oWriteColor equal to the latched colour.
REQ-022 The first write SHALL be presented exactly 2 cycles after the cycle in which iStart is sampled.
REQ-023 A write SHALL complete only in a cycle where oWriteEnable=1 and iWriteGrant=1; while iWriteGrant=0, address and colour SHALL hold with no skipped or duplicated pixel.
REQ-024 On a completed write with col<xEnd: col is incremented.
REQ-025 On a completed write with col==xEnd and row<yEnd: col=latched iX and row is incremented.
REQ-026 On a completed write with col==xEnd and row==yEnd: oWriteEnable drops on the next cycle and the FSM goes to DONE.
REQ-027 Scan order SHALL be row-major, left to right then top to bottom, with at most one write per cycle.
REQ-028 DONE: oDone=1 for exactly one cycle, then return to IDLE; oBusy SHALL be 0 on the cycle after DONE.
REQ-029 iStart SHALL be ignored in SETUP, FILL and DONE; the active job's parameters SHALL be unaffected by input changes after the latch.
REQ-030 A new iStart is accepted no earlier than the cycle after DONE.
REQ-031 oWriteEnable=0 implies oWriteAddress and oWriteColor are don't-care, but they SHALL be held at 0 in IDLE.

Reset
REQ-032 On Reset=1 at a clock edge, the FSM SHALL enter IDLE and oWriteEnable, oWriteAddress, oWriteColor, oBusy and oDone SHALL all be 0 after that edge.
REQ-033 Reset SHALL take priority over iStart and iWriteGrant.
REQ-034 Reset asserted mid-FILL SHALL abort the job with no further writes and no oDone pulse.

Verification
V-1 Assert Reset for 2 cycles -> all outputs 0, oBusy=0.
V-2 Start iX=2, iY=2, iWidth=4, iHeight=4, iColor=RED, iWriteGrant held 1 -> 25 writes on consecutive cycles at addresses 202..206, 302..306, 402..406, 502..506, 602..606; first write 2 cycles after start; oDone 1 cycle after the last write.
V-3 Clipping: iX=97, iY=98, iWidth=4, iHeight=4 -> 6 writes at addresses 9897, 9898, 9899, 9997, 9998, 9999, then oDone.
V-4 Stall: repeat V-2 with iWriteGrant alternating 0,1 (plus a random pattern) -> same 25 addresses in order, each accepted once; address stable while grant is 0.
V-5 Out of range: iX=100 (and separately iY=120) -> no oWriteEnable; oDone pulses 2 cycles after start.
V-6 Reset during the 10th write of V-2 -> oWriteEnable=0 on the next cycle, no oDone; iStart pulsed during FILL in another run is ignored and the write count stays 25.

Source files
------------

// File: rtl/rect_fill_ctrl.sv
// rect_fill_ctrl
//   Walks an axis-aligned rectangle in row-major order and issues one
//   framebuffer pixel write per granted cycle. The rectangle is clipped
//   to the COLS x ROWS framebuffer; a rectangle whose origin lies outside
//   the framebuffer completes without any write.
//
// Ports
//   Clock          in   system clock (all state changes on rising edge)
//   Reset          in   synchronous, active-high reset
//   iStart         in   fill request, sampled only while idle
//   iX, iY         in   top-left column / row of the rectangle
//   iWidth,iHeight in   inclusive extent (columns iX..iX+iWidth, rows iY..iY+iHeight)
//   iColor         in   fill colour
//   iWriteGrant    in   arbiter accepts the presented write this cycle
//   oWriteEnable   out  pixel write request
//   oWriteAddress  out  pixel address, row*COLS+col
//   oWriteColor    out  pixel colour
//   oBusy          out  high whenever a job is in progress
//   oDone          out  one-cycle completion pulse
module rect_fill_ctrl #(
   parameter int COLS = 100,
   parameter int ROWS = 100
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        iStart,
   input  logic [7:0]  iX,
   input  logic [7:0]  iY,
   input  logic [7:0]  iWidth,
   input  logic [7:0]  iHeight,
   input  logic [2:0]  iColor,
   input  logic        iWriteGrant,
   output logic        oWriteEnable,
   output logic [13:0] oWriteAddress,
   output logic [2:0]  oWriteColor,
   output logic        oBusy,
   output logic        oDone
);

   localparam logic [8:0]  X_MAX  = 9'(COLS - 1);
   localparam logic [8:0]  Y_MAX  = 9'(ROWS - 1);
   localparam logic [13:0] COLS14 = 14'(COLS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_FILL,
      S_DONE
   } state_t;

   state_t      r_state;

   // Job parameters latched at the start request
   logic [7:0]  r_x;
   logic [7:0]  r_y;
   logic [2:0]  r_color;
   logic [8:0]  r_x_sum;
   logic [8:0]  r_y_sum;

   // Scan state
   logic [8:0]  r_x_end;
   logic [8:0]  r_y_end;
   logic [8:0]  r_col;
   logic [8:0]  r_row;
   logic [13:0] r_row_base;   // r_row * COLS, kept incrementally

   // Registered outputs
   logic        r_we;
   logic [13:0] r_addr;
   logic [2:0]  r_wcolor;
   logic        r_busy;
   logic        r_done;

   logic [13:0] w_base_start;
   logic        w_out_of_range;
   logic [8:0]  w_x_end;
   logic [8:0]  w_y_end;
   logic [13:0] w_next_row_base;

   always_comb begin
      w_base_start    = 14'(r_y) * COLS14;
      w_out_of_range  = ({1'b0, r_x} > X_MAX) || ({1'b0, r_y} > Y_MAX);
      w_x_end         = (r_x_sum > X_MAX) ? X_MAX : r_x_sum;
      w_y_end         = (r_y_sum > Y_MAX) ? Y_MAX : r_y_sum;
      w_next_row_base = r_row_base + COLS14;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state    <= S_IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_color    <= '0;
         r_x_sum    <= '0;
         r_y_sum    <= '0;
         r_x_end    <= '0;
         r_y_end    <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_row_base <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wcolor   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_we     <= 1'b0;
               r_addr   <= '0;
               r_wcolor <= '0;
               r_done   <= 1'b0;
               if (iStart) begin
                  r_x     <= iX;
                  r_y     <= iY;
                  r_color <= iColor;
                  // 9-bit sums so a large extent cannot wrap below the origin
                  r_x_sum <= {1'b0, iX} + {1'b0, iWidth};
                  r_y_sum <= {1'b0, iY} + {1'b0, iHeight};
                  r_busy  <= 1'b1;
                  r_state <= S_SETUP;
               end else begin
                  r_busy  <= 1'b0;
               end
            end

            S_SETUP: begin
               r_x_end    <= w_x_end;
               r_y_end    <= w_y_end;
               r_col      <= {1'b0, r_x};
               r_row      <= {1'b0, r_y};
               r_row_base <= w_base_start;
               if (w_out_of_range) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  // First pixel is presented directly from the setup cycle
                  r_we     <= 1'b1;
                  r_addr   <= w_base_start + 14'(r_x);
                  r_wcolor <= r_color;
                  r_state  <= S_FILL;
               end
            end

            S_FILL: begin
               // oWriteEnable is constantly high here, so a grant completes the write
               if (iWriteGrant) begin
                  if (r_col < r_x_end) begin
                     r_col  <= r_col + 9'd1;
                     r_addr <= r_addr + 14'd1;
                  end else if (r_row < r_y_end) begin
                     r_col      <= {1'b0, r_x};
                     r_row      <= r_row + 9'd1;
                     r_row_base <= w_next_row_base;
                     r_addr     <= w_next_row_base + 14'(r_x);
                  end else begin
                     r_we     <= 1'b0;
                     r_addr   <= '0;
                     r_wcolor <= '0;
                     r_done   <= 1'b1;
                     r_state  <= S_DONE;
                  end
               end
            end

            S_DONE: begin
               r_done   <= 1'b0;
               r_busy   <= 1'b0;
               r_we     <= 1'b0;
               r_addr   <= '0;
               r_wcolor <= '0;
               r_state  <= S_IDLE;
            end

            default: begin
               r_we    <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign oWriteEnable  = r_we;
   assign oWriteAddress = r_addr;
   assign oWriteColor   = r_wcolor;
   assign oBusy         = r_busy;
   assign oDone         = r_done;

endmodule

// File: tb/tb_rect_fill_ctrl.sv
// tb_rect_fill_ctrl
//   Self-checking bench for rect_fill_ctrl. Expected pixel writes are
//   pushed to a scoreboard queue when a job is started and popped as the
//   DUT completes granted writes.
module tb_rect_fill_ctrl;

   localparam int COLS = 100;
   localparam int ROWS = 100;
   localparam logic [2:0] RED   = 3'b100;
   localparam logic [2:0] GREEN = 3'b010;
   localparam logic [2:0] BLUE  = 3'b001;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        iStart;
   logic [7:0]  iX, iY, iWidth, iHeight;
   logic [2:0]  iColor;
   logic        iWriteGrant;
   logic        oWriteEnable;
   logic [13:0] oWriteAddress;
   logic [2:0]  oWriteColor;
   logic        oBusy;
   logic        oDone;

   rect_fill_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .iStart        (iStart),
      .iX            (iX),
      .iY            (iY),
      .iWidth        (iWidth),
      .iHeight       (iHeight),
      .iColor        (iColor),
      .iWriteGrant   (iWriteGrant),
      .oWriteEnable  (oWriteEnable),
      .oWriteAddress (oWriteAddress),
      .oWriteColor   (oWriteColor),
      .oBusy         (oBusy),
      .oDone         (oDone)
   );

   always #5 Clock = ~Clock;

   typedef struct packed {
      logic [13:0] addr;
      logic [2:0]  color;
   } wr_t;

   wr_t sb[$];

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int g_mode  = 0;   // 0: grant always, 1: alternating, 2: random
   int n_writes = 0, n_done = 0, first_we = -1, last_wr = -1, done_cyc = -1, we_seen = 0;

   logic        prev_stall = 1'b0;
   logic [13:0] prev_addr  = '0;
   logic [2:0]  prev_color = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   task automatic clear_track();
      n_writes = 0;
      n_done   = 0;
      first_we = -1;
      last_wr  = -1;
      done_cyc = -1;
      we_seen  = 0;
   endtask

   initial forever begin
      @(posedge Clock);
      cyc++;
   end

   // Grant generator
   initial begin
      iWriteGrant = 1'b1;
      forever begin
         @(posedge Clock);
         #1;
         case (g_mode)
            1:       iWriteGrant = ~iWriteGrant;
            2:       iWriteGrant = 1'($urandom_range(0, 1));
            default: iWriteGrant = 1'b1;
         endcase
      end
   end

   // Output monitor / scoreboard consumer
   initial forever begin
      @(negedge Clock);
      if (oWriteEnable) begin
         we_seen++;
         if (first_we < 0) first_we = cyc;
      end
      if (prev_stall && oWriteEnable) begin
         chk("hold_addr", 32'(oWriteAddress), 32'(prev_addr));
         chk("hold_color", 32'(oWriteColor), 32'(prev_color));
      end
      prev_stall = oWriteEnable && !iWriteGrant;
      prev_addr  = oWriteAddress;
      prev_color = oWriteColor;
      if (oWriteEnable && iWriteGrant) begin
         n_writes++;
         last_wr = cyc;
         if (sb.size() == 0) begin
            chk("extra_write", 32'(oWriteAddress), 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = sb.pop_front();
            chk("wr_addr", 32'(oWriteAddress), 32'(e.addr));
            chk("wr_color", 32'(oWriteColor), 32'(e.color));
         end
      end
      if (oDone) begin
         n_done++;
         done_cyc = cyc;
      end
   end

   task automatic push_expected(input int x, input int y, input int w, input int h,
                                input logic [2:0] col, input int limit, output int nexp);
      int xe, ye;
      wr_t e;
      nexp = 0;
      if (x < COLS && y < ROWS) begin
         xe = (x + w > COLS - 1) ? COLS - 1 : x + w;
         ye = (y + h > ROWS - 1) ? ROWS - 1 : y + h;
         for (int r = y; r <= ye; r++) begin
            for (int c = x; c <= xe; c++) begin
               if (nexp < limit) begin
                  e.addr  = 14'(r * COLS + c);
                  e.color = col;
                  sb.push_back(e);
                  nexp++;
               end
            end
         end
      end
   endtask

   task automatic start_job(input int x, input int y, input int w, input int h,
                            input logic [2:0] col, output int start);
      @(posedge Clock);
      #1;
      iStart  = 1'b1;
      iX      = 8'(x);
      iY      = 8'(y);
      iWidth  = 8'(w);
      iHeight = 8'(h);
      iColor  = col;
      start   = cyc;
      @(posedge Clock);
      #1;
      // scramble inputs after the latch; the job must not see them
      iStart  = 1'b0;
      iX      = 8'($urandom);
      iY      = 8'($urandom);
      iWidth  = 8'($urandom);
      iHeight = 8'($urandom);
      iColor  = 3'($urandom);
   endtask

   task automatic run_job(input string nm, input int x, input int y, input int w, input int h,
                          input logic [2:0] col, input int mode, input bit poke);
      int nexp, start;
      g_mode = mode;
      clear_track();
      push_expected(x, y, w, h, col, 1 << 30, nexp);
      start_job(x, y, w, h, col, start);
      if (poke) begin
         repeat (6) @(posedge Clock);
         #1;
         iStart = 1'b1; iX = 8'd0; iY = 8'd0; iWidth = 8'd10; iHeight = 8'd10;
         @(posedge Clock);
         #1;
         iStart = 1'b0;
      end
      for (int i = 0; i < 4000 && n_done == 0; i++) begin
         @(negedge Clock);
         #1;
      end
      chk({nm, "_done_seen"}, 32'(n_done), 32'd1);
      chk({nm, "_busy_in_done"}, 32'(oBusy), 32'd1);
      if (nexp > 0) begin
         chk({nm, "_first_latency"}, 32'(first_we - start), 32'd2);
         chk({nm, "_done_latency"}, 32'(done_cyc - last_wr), 32'd1);
      end else begin
         chk({nm, "_no_write"}, 32'(we_seen), 32'd0);
         chk({nm, "_done_latency"}, 32'(done_cyc - start), 32'd2);
      end
      chk({nm, "_writes"}, 32'(n_writes), 32'(nexp));
      chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
      if (mode == 0 && nexp > 0)
         chk({nm, "_back_to_back"}, 32'(last_wr - first_we), 32'(nexp - 1));
      @(negedge Clock);
      chk({nm, "_done_len"}, 32'(oDone), 32'd0);
      chk({nm, "_busy_after"}, 32'(oBusy), 32'd0);
      chk({nm, "_idle_addr"}, 32'(oWriteAddress), 32'd0);
      chk({nm, "_idle_color"}, 32'(oWriteColor), 32'd0);
      chk({nm, "_idle_we"}, 32'(oWriteEnable), 32'd0);
      sb.delete();
   endtask

   task automatic reset_check();
      Reset  = 1'b1;
      iStart = 1'b1;   // reset must win over a start request
      iX = 8'd2; iY = 8'd2; iWidth = 8'd4; iHeight = 8'd4; iColor = RED;
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      chk("rst_we", 32'(oWriteEnable), 32'd0);
      chk("rst_addr", 32'(oWriteAddress), 32'd0);
      chk("rst_color", 32'(oWriteColor), 32'd0);
      chk("rst_busy", 32'(oBusy), 32'd0);
      chk("rst_done", 32'(oDone), 32'd0);
      @(posedge Clock);
      #1;
      Reset  = 1'b0;
      iStart = 1'b0;
      @(negedge Clock);
      chk("post_rst_busy", 32'(oBusy), 32'd0);
   endtask

   task automatic reset_mid_fill();
      int nexp, start;
      g_mode = 0;
      clear_track();
      push_expected(2, 2, 4, 4, RED, 10, nexp);
      start_job(2, 2, 4, 4, RED, start);
      repeat (10) @(posedge Clock);
      #1;
      Reset = 1'b1;
      @(negedge Clock);
      chk("mid_10th_we", 32'(oWriteEnable), 32'd1);
      chk("mid_10th_addr", 32'(oWriteAddress), 32'd306);
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      @(negedge Clock);
      chk("mid_we_after_rst", 32'(oWriteEnable), 32'd0);
      repeat (30) @(negedge Clock);
      chk("mid_we_cycles", 32'(we_seen), 32'd10);
      chk("mid_writes", 32'(n_writes), 32'd10);
      chk("mid_no_done", 32'(n_done), 32'd0);
      chk("mid_busy", 32'(oBusy), 32'd0);
      chk("mid_sb_empty", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1; iStart = 1'b0;
      iX = '0; iY = '0; iWidth = '0; iHeight = '0; iColor = '0;
      reset_check();
      run_job("v2",      2,   2,   4,   4, RED,   0, 1'b0);
      run_job("v3",      97,  98,  4,   4, GREEN, 0, 1'b0);
      run_job("v4_alt",  2,   2,   4,   4, RED,   1, 1'b0);
      run_job("v4_rnd",  2,   2,   4,   4, BLUE,  2, 1'b0);
      run_job("v5_x",    100, 10,  3,   3, RED,   0, 1'b0);
      run_job("v5_y",    10,  120, 3,   3, RED,   0, 1'b0);
      run_job("single",  99,  99,  0,   0, GREEN, 0, 1'b0);
      run_job("nowrap",  50,  10,  250, 1, BLUE,  2, 1'b0);
      run_job("row0",    0,   0,   255, 0, 3'b111, 1, 1'b0);
      run_job("poke",    2,   2,   4,   4, RED,   0, 1'b1);
      reset_mid_fill();
      run_job("recover", 2,   2,   4,   4, RED,   0, 1'b0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
